// File: rtl/rv_trace_seq_checker.sv
// rtl/rv_trace_seq_checker.sv - programmable ordered-milestone checker for the RV32 execution trace
// Observes pc/addr/rdId/leds and walks a step table, flagging pass, fail or inter-step timeout.
module rv_trace_seq_checker #(
  parameter int NUM_STEPS = 4,
  parameter int LED_W     = 5,
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 1000,
  localparam int IDX_W    = $clog2(NUM_STEPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic [31:0]      addr,
  input  logic [4:0]       rdId,
  input  logic [LED_W-1:0] leds,
  input  logic             sample_en,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [31:0]      cfg_pc,
  input  logic [31:0]      cfg_addr,
  input  logic [4:0]       cfg_rd,
  input  logic [LED_W-1:0] cfg_leds,
  input  logic [3:0]       cfg_mask,
  input  logic             cfg_last,
  input  logic             arm,
  input  logic             abort,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [IDX_W-1:0] step_idx,
  output logic             match_pulse
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_STEPS - 1);
  localparam logic [TIMEOUT_W-1:0] TO_VAL   = TIMEOUT_W'(TIMEOUT);

  state_t               state_q;
  logic                 busy_q, pass_q, fail_q, match_pulse_q;
  logic [IDX_W-1:0]     step_idx_q;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      tbl_pc_q   [NUM_STEPS];
  logic [31:0]      tbl_addr_q [NUM_STEPS];
  logic [4:0]       tbl_rd_q   [NUM_STEPS];
  logic [LED_W-1:0] tbl_leds_q [NUM_STEPS];
  logic [3:0]       tbl_mask_q [NUM_STEPS];
  logic             tbl_last_q [NUM_STEPS];

  logic step_hit, step_final, timeout_hit;
  logic [3:0] cur_mask;

  always_comb begin
    cur_mask   = tbl_mask_q[step_idx_q];
    step_hit   = sample_en
               && (!cur_mask[0] || (pc   == tbl_pc_q[step_idx_q]))
               && (!cur_mask[1] || (addr == tbl_addr_q[step_idx_q]))
               && (!cur_mask[2] || (rdId == tbl_rd_q[step_idx_q]))
               && (!cur_mask[3] || (leds == tbl_leds_q[step_idx_q]));
    step_final = tbl_last_q[step_idx_q] || (step_idx_q == LAST_IDX);
    cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + TIMEOUT_W'(1);
    // The cycle that would bring the counter to TIMEOUT is the one that fails.
    timeout_hit = (TIMEOUT != 0) && (cnt_d == TO_VAL);
  end

  // Table is frozen while a sequence is running so compares stay coherent.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        tbl_pc_q[i]   <= '0;
        tbl_addr_q[i] <= '0;
        tbl_rd_q[i]   <= '0;
        tbl_leds_q[i] <= '0;
        tbl_mask_q[i] <= '0;
        tbl_last_q[i] <= 1'b0;
      end
    end else if (cfg_we && (state_q != S_RUN)) begin
      tbl_pc_q[cfg_idx]   <= cfg_pc;
      tbl_addr_q[cfg_idx] <= cfg_addr;
      tbl_rd_q[cfg_idx]   <= cfg_rd;
      tbl_leds_q[cfg_idx] <= cfg_leds;
      tbl_mask_q[cfg_idx] <= cfg_mask;
      tbl_last_q[cfg_idx] <= cfg_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      match_pulse_q <= 1'b0;
      step_idx_q    <= '0;
      cnt_q         <= '0;
    end else begin
      match_pulse_q <= 1'b0;
      if (abort) begin
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        pass_q     <= 1'b0;
        fail_q     <= 1'b0;
        step_idx_q <= '0;
        cnt_q      <= '0;
      end else if (arm) begin
        state_q    <= S_RUN;
        busy_q     <= 1'b1;
        pass_q     <= 1'b0;
        fail_q     <= 1'b0;
        step_idx_q <= '0;
        cnt_q      <= '0;
      end else if (state_q == S_RUN) begin
        if (step_hit) begin
          match_pulse_q <= 1'b1;
          cnt_q         <= '0;
          if (step_final) begin
            state_q <= S_PASS;
            busy_q  <= 1'b0;
            pass_q  <= 1'b1;
          end else begin
            step_idx_q <= step_idx_q + IDX_W'(1);
          end
        end else if (timeout_hit) begin
          state_q <= S_FAIL;
          busy_q  <= 1'b0;
          fail_q  <= 1'b1;
          cnt_q   <= cnt_d;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  end

  assign busy        = busy_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign step_idx    = step_idx_q;
  assign match_pulse = match_pulse_q;

endmodule

// File: tb/tb_rv_trace_seq_checker.sv
// tb/tb_rv_trace_seq_checker.sv - directed self-checking bench for rv_trace_seq_checker
module tb_rv_trace_seq_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0, addr = '0;
  logic [4:0]  rdId = '0;
  logic [4:0]  leds = '0;
  logic        sample_en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_pc = '0, cfg_addr = '0;
  logic [4:0]  cfg_rd = '0;
  logic [4:0]  cfg_leds = '0;
  logic [3:0]  cfg_mask = '0;
  logic        cfg_last = 1'b0;
  logic        arm = 1'b0, abort = 1'b0;
  logic        busy, pass, fail, match_pulse;
  logic [1:0]  step_idx;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  rv_trace_seq_checker #(.NUM_STEPS(4), .LED_W(5), .TIMEOUT_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .pc(pc), .addr(addr), .rdId(rdId), .leds(leds),
    .sample_en(sample_en), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc),
    .cfg_addr(cfg_addr), .cfg_rd(cfg_rd), .cfg_leds(cfg_leds), .cfg_mask(cfg_mask),
    .cfg_last(cfg_last), .arm(arm), .abort(abort), .busy(busy), .pass(pass),
    .fail(fail), .step_idx(step_idx), .match_pulse(match_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (match_pulse === 1'b1) pulse_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] p, input logic [31:0] a, input logic [4:0] r, input logic [4:0] l);
    pc = p; addr = a; rdId = r; leds = l;
  endtask

  task automatic drive_idle(); set_in(32'hFFFF_FFF0, 32'h0, 5'd1, 5'h00); endtask
  task automatic drive_ev0();  set_in(32'h0000_002C, 32'h0, 5'd1, 5'h0E); endtask
  task automatic drive_ev1();  set_in(32'hFFFF_FFF0, 32'h36, 5'h1E, 5'h00); endtask
  task automatic drive_ev2();  set_in(32'hFFFF_FFF0, 32'h0, 5'd0, 5'h00); endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [31:0] p, input logic [31:0] a,
                           input logic [4:0] r, input logic [4:0] l, input logic [3:0] m, input logic last);
    cfg_idx = idx; cfg_pc = p; cfg_addr = a; cfg_rd = r; cfg_leds = l; cfg_mask = m; cfg_last = last;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (pass !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL reset_pass_fail: got %0b/%0b want 0/0", pass, fail); end
    checks++; if (match_pulse !== 1'b0 || step_idx !== 2'd0) begin errors++; $display("FAIL reset_pulse_idx: got %0b/%0d want 0/0", match_pulse, step_idx); end
  endtask

  task automatic test_three_step();
    cfg_write(2'd0, 32'h2C, 32'h0, 5'd0, 5'h0E, 4'b1001, 1'b0);
    cfg_write(2'd1, 32'h0, 32'h36, 5'h1E, 5'h00, 4'b0110, 1'b0);
    cfg_write(2'd2, 32'h0, 32'h0, 5'd0, 5'h00, 4'b0100, 1'b1);
    sample_en = 1'b1;
    drive_idle();
    do_arm();
    pulse_cnt = 0;
    checks++; if (busy !== 1'b1 || step_idx !== 2'd0) begin errors++; $display("FAIL arm_busy_idx: got %0b/%0d want 1/0", busy, step_idx); end
    repeat (4) tick();
    drive_ev0(); tick(); drive_idle();
    checks++; if (match_pulse !== 1'b1 || step_idx !== 2'd1) begin errors++; $display("FAIL seq_step0: got pulse=%0b idx=%0d want 1/1", match_pulse, step_idx); end
    tick();
    checks++; if (match_pulse !== 1'b0) begin errors++; $display("FAIL seq_pulse_width: got %0b want 0", match_pulse); end
    repeat (3) tick();
    drive_ev1(); tick(); drive_idle();
    checks++; if (match_pulse !== 1'b1 || step_idx !== 2'd2) begin errors++; $display("FAIL seq_step1: got pulse=%0b idx=%0d want 1/2", match_pulse, step_idx); end
    repeat (4) tick();
    checks++; if (pass !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL seq_pre_pass: got pass=%0b busy=%0b want 0/1", pass, busy); end
    drive_ev2(); tick(); drive_idle();
    checks++; if (pass !== 1'b1 || fail !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL seq_pass: got pass=%0b fail=%0b busy=%0b want 1/0/0", pass, fail, busy); end
    tick();
    checks++; if (pass !== 1'b1 || pulse_cnt !== 3) begin errors++; $display("FAIL seq_sticky_pulses: got pass=%0b pulses=%0d want 1/3", pass, pulse_cnt); end
  endtask

  task automatic test_out_of_order();
    drive_idle();
    do_arm();
    drive_ev1(); tick();
    checks++; if (step_idx !== 2'd0 || match_pulse !== 1'b0) begin errors++; $display("FAIL ooo_no_advance: got idx=%0d pulse=%0b want 0/0", step_idx, match_pulse); end
    drive_ev0(); tick();
    drive_ev1(); tick();
    drive_idle();
    checks++; if (step_idx !== 2'd2) begin errors++; $display("FAIL ooo_reach2: got %0d want 2", step_idx); end
    do_abort();
    checks++; if (busy !== 1'b0 || step_idx !== 2'd0) begin errors++; $display("FAIL abort_idle: got busy=%0b idx=%0d want 0/0", busy, step_idx); end
  endtask

  task automatic test_timeout();
    drive_idle();
    do_arm();
    repeat (7) tick();
    checks++; if (fail !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early: got fail=%0b busy=%0b want 0/1", fail, busy); end
    tick();
    checks++; if (fail !== 1'b1 || busy !== 1'b0 || step_idx !== 2'd0) begin errors++; $display("FAIL to_fire: got fail=%0b busy=%0b idx=%0d want 1/0/0", fail, busy, step_idx); end
    tick();
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL to_sticky: got %0b want 1", fail); end
    do_arm();
    checks++; if (busy !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL to_rearm: got busy=%0b fail=%0b want 1/0", busy, fail); end
  endtask

  task automatic test_collision();
    drive_idle();
    do_arm();
    repeat (7) tick();
    drive_ev0(); tick(); drive_idle();
    checks++; if (step_idx !== 2'd1 || fail !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL coll_match_wins: got idx=%0d fail=%0b busy=%0b want 1/0/1", step_idx, fail, busy); end
    repeat (7) tick();
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL coll_cnt_cleared: got fail=%0b want 0", fail); end
    tick();
    checks++; if (fail !== 1'b1 || step_idx !== 2'd1) begin errors++; $display("FAIL coll_stall_idx: got fail=%0b idx=%0d want 1/1", fail, step_idx); end
  endtask

  task automatic test_sample_en();
    sample_en = 1'b0;
    drive_ev0();
    do_arm();
    repeat (3) tick();
    checks++; if (step_idx !== 2'd0 || match_pulse !== 1'b0) begin errors++; $display("FAIL sen_gated: got idx=%0d pulse=%0b want 0/0", step_idx, match_pulse); end
    sample_en = 1'b1; tick();
    checks++; if (step_idx !== 2'd1) begin errors++; $display("FAIL sen_enabled: got %0d want 1", step_idx); end
    do_abort();
    cfg_write(2'd0, 32'h0, 32'h0, 5'd0, 5'h00, 4'b0000, 1'b0);
    sample_en = 1'b0;
    drive_idle();
    do_arm();
    repeat (2) tick();
    checks++; if (step_idx !== 2'd0) begin errors++; $display("FAIL wild_gated: got %0d want 0", step_idx); end
    sample_en = 1'b1; tick();
    checks++; if (step_idx !== 2'd1 || match_pulse !== 1'b1) begin errors++; $display("FAIL wild_advance: got idx=%0d pulse=%0b want 1/1", step_idx, match_pulse); end
    do_abort();
  endtask

  task automatic test_cfg_run_and_reset();
    cfg_write(2'd0, 32'h2C, 32'h0, 5'd0, 5'h00, 4'b0001, 1'b0);
    sample_en = 1'b1;
    drive_idle();
    do_arm();
    cfg_write(2'd0, 32'h0, 32'h0, 5'd0, 5'h00, 4'b0000, 1'b1);
    tick();
    checks++; if (step_idx !== 2'd0 || pass !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL cfg_run_ignored: got idx=%0d pass=%0b busy=%0b want 0/0/1", step_idx, pass, busy); end
    drive_ev0(); tick(); drive_idle();
    checks++; if (step_idx !== 2'd1) begin errors++; $display("FAIL cfg_run_kept: got %0d want 1", step_idx); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || match_pulse !== 1'b0 || step_idx !== 2'd0) begin
      errors++; $display("FAIL midrun_reset: got busy=%0b pass=%0b fail=%0b pulse=%0b idx=%0d want all 0", busy, pass, fail, match_pulse, step_idx);
    end
    do_arm();
    tick();
    checks++; if (step_idx !== 2'd1 || match_pulse !== 1'b1) begin errors++; $display("FAIL cleared_first: got idx=%0d pulse=%0b want 1/1", step_idx, match_pulse); end
    repeat (2) tick();
    checks++; if (step_idx !== 2'd3 || pass !== 1'b0) begin errors++; $display("FAIL cleared_step3: got idx=%0d pass=%0b want 3/0", step_idx, pass); end
    tick();
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL cleared_pass: got %0b want 1", pass); end
  endtask

  initial begin
    test_reset();
    test_three_step();
    test_out_of_order();
    test_timeout();
    test_collision();
    test_sample_en();
    test_cfg_run_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_trace_seq_checker.md
# rv_trace_seq_checker

Synthesizable, parametrised sequence checker for the RV32 core's execution trace. It watches the core's debug outputs (`pc`, `rdId`, `addr`, `leds`) for an ordered list of programmable match steps. It reports pass, fail, or timeout so that both simulation benches and on-board self-test can detect program milestones. It sits beside the `RiscV` top level and only observes: it never drives core signals.

## Interface
Parameters:
- `NUM_STEPS`, 4: depth of the step table (2..16).
- `LED_W`, 5: width of the `leds` field.
- `TIMEOUT_W`, 16: width of the inter-step cycle counter.
- `TIMEOUT`, 1000: maximum cycles allowed between step advances; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset, sampled on rising `clk`. One clock; reset is synchronous and active-high.
- `pc`  in  32  core program counter.
- `addr`  in  32  core memory address.
- `rdId`  in  5  core destination register index.
- `leds`  in  `LED_W`  core LED output.
- `sample_en`  in  1  compare qualifier; no match is evaluated when low.
- `cfg_we`  in  1  step-table write strobe.
- `cfg_idx`  in  `$clog2(NUM_STEPS)`  step index being written.
- `cfg_pc`, `cfg_addr`  in  32  compare values.
- `cfg_rd`  in  5  compare value.
- `cfg_leds`  in  `LED_W`  compare value.
- `cfg_mask`  in  4  field enables: bit0 `pc`, bit1 `addr`, bit2 `rdId`, bit3 `leds`.
- `cfg_last`  in  1  marks this step as the final step.
- `arm`  in  1  start or restart the sequence (pulse).
- `abort`  in  1  return to IDLE.
- `busy`  out  1  high in RUN.
- `pass`  out  1  sticky, high in PASS.
- `fail`  out  1  sticky, high in FAIL.
- `step_idx`  out  `$clog2(NUM_STEPS)`  current step.
- `match_pulse`  out  1  one-cycle pulse per step advance.

## Operation
- States: IDLE, RUN, PASS, FAIL (2-bit encoded).
- **Step table:** holds `NUM_STEPS` entries of {pc, addr, rd, leds, mask, last}. Writes land on rising `clk` when `cfg_we`=1, and are accepted in IDLE, PASS, and FAIL only. Writes in RUN are ignored.
- **Step match:** step *i* matches when `sample_en`=1 and every field enabled in its mask equals the corresponding input. A mask of 0 matches on any sampled cycle.
- **Final step:** a step is final if its `last`=1 or *i*=`NUM_STEPS`-1.
- **IDLE:**
  - `arm` → RUN, `step_idx`=0, timeout counter=0.
- **RUN:**
  - Match on a non-final step: `step_idx`+1, counter cleared, `match_pulse`.
  - Match on the final step: → PASS, `match_pulse`.
  - No match: counter +1, saturating at 2^`TIMEOUT_W`-1.
  - Counter reaches `TIMEOUT` (when `TIMEOUT`≠0) with no match in that cycle: → FAIL. `step_idx` is held to show the stalled step.
- **PASS / FAIL:** hold until `arm`, which restarts into RUN at step 0, or until `abort`/`reset`.
- **Priority, highest first:** `reset` > `abort` > `arm` > match > timeout. A match in the same cycle the counter hits `TIMEOUT` counts as a match. `arm` during RUN restarts at step 0.
- Only one step can advance per cycle, even if the next step would also match the same inputs.

## Timing
- **Reset values:**
  - state IDLE.
  - `busy`, `pass`, `fail`, `match_pulse` = 0.
  - `step_idx` = 0, counter = 0.
  - Every table entry: mask 0, last 0, value fields 0.
- `arm` sampled at edge *n* → `busy`=1 after edge *n*. The first compare happens in cycle *n*+1.
- Compare is combinational on same-cycle inputs. `step_idx`, state, and `match_pulse` update at the next edge, so there is 1-cycle latency from matching inputs to `match_pulse`/`pass`.
- Timeout: with `TIMEOUT`=T and no match, `fail` rises at the edge ending the T-th RUN cycle after the last advance.
- `abort` or `reset` mid-RUN: IDLE after that edge. The table contents survive `abort` but not `reset`.
- A table write takes effect for compares starting the cycle after the write edge.

## Test plan
- **Three-step milestone sequence:**
  - Setup: step0 {pc=0x2C, leds=0x0E, mask=1001b}; step1 {rd=0x1E, addr=0x36, mask=0110b}; step2 {rd=0, mask=0100b, last=1}.
  - Stimulus: `arm`, then drive the three events 5 cycles apart.
  - Required: `match_pulse` ×3, `step_idx` 0→1→2, `pass`=1 one cycle after the third event, `fail`=0.
- **Out-of-order events:** present the step1 values before step0. Required: no advance. Then drive step0 followed by step1. Required: `step_idx` reaches 2.
- **Timeout:** `TIMEOUT`=8, arm, never match. Required: `fail`=1 exactly 8 cycles after RUN entry, `step_idx`=0. Then `arm` → `busy`=1, `fail`=0.
- **Match vs timeout collision:** match on the cycle the counter reaches `TIMEOUT`. Required: advance, no `fail`.
- **`sample_en` and wildcard step:** with `sample_en`=0, matching inputs do not advance. A mask=0 step advances on the first cycle with `sample_en`=1.
- **`cfg_we` in RUN; `reset` mid-RUN:** `cfg_we` in RUN leaves the table unchanged. `reset` mid-RUN gives all outputs 0 and a cleared table (a following `arm` passes on the first sampled cycle).
